// File: rtl/ysyx_22050078_pipe_ctrl_pkg.sv
// Shared widths and state encodings for the pipeline hazard controller.
package ysyx_22050078_pipe_ctrl_pkg;

    localparam int unsigned REG_ADDRW = 5;
    localparam int unsigned CPU_WIDTH = 64;

    typedef enum logic [1:0] {
        ST_RUN      = 2'd0,
        ST_MEM_WAIT = 2'd1,
        ST_DISCARD  = 2'd2
    } pipe_state_e;

endpackage

// File: rtl/stl_reg.sv
// Generic register primitive with write enable and asynchronous active-low reset.
module stl_reg #(
    parameter int unsigned         WIDTH     = 1,
    parameter logic [WIDTH-1:0]    RESET_VAL = '0
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             wen,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);

    logic [WIDTH-1:0] data_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            data_q <= RESET_VAL;
        end else if (wen) begin
            data_q <= d;
        end
    end

    assign q = data_q;

endmodule

// File: rtl/ysyx_22050078_hazard_det.sv
// Load-use hazard detection between the EX-stage load and the ID-stage sources.
module ysyx_22050078_hazard_det
    import ysyx_22050078_pipe_ctrl_pkg::*;
(
    input  logic [REG_ADDRW-1:0] i_rs1_addr,
    input  logic [REG_ADDRW-1:0] i_rs2_addr,
    input  logic                 i_rs1_ren,
    input  logic                 i_rs2_ren,
    input  logic [REG_ADDRW-1:0] i_rd_addr,
    input  logic                 i_ld_en,
    output logic                 o_load_use_c
);

    // x0 never carries a dependency
    always_comb begin
        o_load_use_c = i_ld_en & (i_rd_addr != '0) &
                       ((i_rs1_ren & (i_rs1_addr == i_rd_addr)) |
                        (i_rs2_ren & (i_rs2_addr == i_rd_addr)));
    end

endmodule

// File: rtl/ysyx_22050078_pipe_ctrl.sv
// Pipeline stall/flush controller: memory freeze, redirect flush, load-use bubble,
// discard of a stale in-flight fetch, and stall/flush performance counters.
module ysyx_22050078_pipe_ctrl
    import ysyx_22050078_pipe_ctrl_pkg::*;
(
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [REG_ADDRW-1:0] i_id_rs1_addr,
    input  logic [REG_ADDRW-1:0] i_id_rs2_addr,
    input  logic                 i_id_rs1_ren,
    input  logic                 i_id_rs2_ren,
    input  logic [REG_ADDRW-1:0] i_ex_rd_addr,
    input  logic                 i_ex_ld_en,
    input  logic                 i_ex_redirect,
    input  logic                 i_lsu_req,
    input  logic                 i_lsu_ready,
    input  logic                 i_ifu_busy,
    input  logic                 i_ifu_valid,
    output logic                 o_pc_stall,
    output logic                 o_ifid_stall,
    output logic                 o_ifid_flush,
    output logic                 o_idex_bubble,
    output logic                 o_exls_stall,
    output logic                 o_ifu_drop,
    output logic [CPU_WIDTH-1:0] o_stall_cnt,
    output logic [CPU_WIDTH-1:0] o_flush_cnt
);

    pipe_state_e          state_q, state_d;
    logic                 load_use;
    logic                 mem_block;
    logic                 redirect_acc;
    logic [CPU_WIDTH-1:0] stall_cnt_q, stall_cnt_d;
    logic [CPU_WIDTH-1:0] flush_cnt_q, flush_cnt_d;

    ysyx_22050078_hazard_det u_hazard_det (
        .i_rs1_addr   (i_id_rs1_addr),
        .i_rs2_addr   (i_id_rs2_addr),
        .i_rs1_ren    (i_id_rs1_ren),
        .i_rs2_ren    (i_id_rs2_ren),
        .i_rd_addr    (i_ex_rd_addr),
        .i_ld_en      (i_ex_ld_en),
        .o_load_use_c (load_use)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_RUN;
        end else begin
            state_q <= state_d;
        end
    end

    // Priority: memory freeze, then redirect flush, then load-use bubble
    always_comb begin
        mem_block     = i_lsu_req & ~i_lsu_ready;
        redirect_acc  = i_ex_redirect & ~mem_block;
        state_d       = state_q;
        o_pc_stall    = 1'b0;
        o_ifid_stall  = 1'b0;
        o_ifid_flush  = 1'b0;
        o_idex_bubble = 1'b0;
        o_exls_stall  = 1'b0;
        o_ifu_drop    = 1'b0;

        if (rst_n) begin
            if (mem_block) begin
                o_pc_stall   = 1'b1;
                o_ifid_stall = 1'b1;
                o_exls_stall = 1'b1;
            end else if (i_ex_redirect) begin
                o_ifid_flush  = 1'b1;
                o_idex_bubble = 1'b1;
            end else if (load_use) begin
                o_pc_stall    = 1'b1;
                o_ifid_stall  = 1'b1;
                o_idex_bubble = 1'b1;
            end
            o_ifu_drop = (state_q == ST_DISCARD) & i_ifu_valid;
        end

        // Only one fetch may be outstanding, so a redirect inside DISCARD stays there
        case (state_q)
            ST_DISCARD: begin
                if (redirect_acc & i_ifu_busy) begin
                    state_d = ST_DISCARD;
                end else if (i_ifu_valid) begin
                    state_d = mem_block ? ST_MEM_WAIT : ST_RUN;
                end
            end
            default: begin
                if (mem_block) begin
                    state_d = ST_MEM_WAIT;
                end else if (redirect_acc & i_ifu_busy) begin
                    state_d = ST_DISCARD;
                end else begin
                    state_d = ST_RUN;
                end
            end
        endcase
    end

    always_comb begin
        stall_cnt_d = stall_cnt_q + CPU_WIDTH'(1);
        flush_cnt_d = flush_cnt_q + CPU_WIDTH'(1);
    end

    stl_reg #(.WIDTH(CPU_WIDTH), .RESET_VAL('0)) u_stall_cnt (
        .clk   (clk),
        .rst_n (rst_n),
        .wen   (o_pc_stall),
        .d     (stall_cnt_d),
        .q     (stall_cnt_q)
    );

    stl_reg #(.WIDTH(CPU_WIDTH), .RESET_VAL('0)) u_flush_cnt (
        .clk   (clk),
        .rst_n (rst_n),
        .wen   (o_ifid_flush),
        .d     (flush_cnt_d),
        .q     (flush_cnt_q)
    );

    assign o_stall_cnt = stall_cnt_q;
    assign o_flush_cnt = flush_cnt_q;

endmodule

// File: tb/tb_ysyx_22050078_pipe_ctrl.sv
// Self-checking bench: directed scenarios with literal expectations, then random traffic
// checked every cycle against a behavioural model of the hazard rules.
module tb_ysyx_22050078_pipe_ctrl;
    import ysyx_22050078_pipe_ctrl_pkg::*;

    logic                 clk = 1'b0;
    logic                 rst_n;
    logic [REG_ADDRW-1:0] rs1, rs2, rd;
    logic                 ren1, ren2, ld_en, redirect, lsu_req, lsu_ready, ifu_busy, ifu_valid;
    logic                 pc_stall, ifid_stall, ifid_flush, idex_bubble, exls_stall, ifu_drop;
    logic [CPU_WIDTH-1:0] stall_cnt, flush_cnt;

    int n_cmp = 0;
    int n_bad = 0;

    // Model state: whether a stale fetch is still to be dropped, plus counter values
    bit                   m_disc = 1'b0;
    logic [CPU_WIDTH-1:0] m_stall = '0;
    logic [CPU_WIDTH-1:0] m_flush = '0;

    ysyx_22050078_pipe_ctrl dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .i_id_rs1_addr (rs1),
        .i_id_rs2_addr (rs2),
        .i_id_rs1_ren  (ren1),
        .i_id_rs2_ren  (ren2),
        .i_ex_rd_addr  (rd),
        .i_ex_ld_en    (ld_en),
        .i_ex_redirect (redirect),
        .i_lsu_req     (lsu_req),
        .i_lsu_ready   (lsu_ready),
        .i_ifu_busy    (ifu_busy),
        .i_ifu_valid   (ifu_valid),
        .o_pc_stall    (pc_stall),
        .o_ifid_stall  (ifid_stall),
        .o_ifid_flush  (ifid_flush),
        .o_idex_bubble (idex_bubble),
        .o_exls_stall  (exls_stall),
        .o_ifu_drop    (ifu_drop),
        .o_stall_cnt   (stall_cnt),
        .o_flush_cnt   (flush_cnt)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [CPU_WIDTH-1:0] act, input logic [CPU_WIDTH-1:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Per-cycle reference check; model advances once per cycle after the compare
    always @(negedge clk) begin : model_chk
        bit mb, lu, e_stall, e_flush, e_bub, e_drop;
        if (!rst_n) begin
            m_disc  = 1'b0;
            m_stall = '0;
            m_flush = '0;
            mb = 1'b0; e_stall = 1'b0; e_flush = 1'b0; e_bub = 1'b0; e_drop = 1'b0;
        end else begin
            mb = lsu_req && !lsu_ready;
            lu = ld_en && (rd != 0) && ((ren1 && rs1 == rd) || (ren2 && rs2 == rd));
            e_stall = mb || (!redirect && lu);
            e_flush = !mb && redirect;
            e_bub   = !mb && (redirect || lu);
            e_drop  = m_disc && ifu_valid;
        end
        chk("m_pc_stall",    CPU_WIDTH'(pc_stall),    CPU_WIDTH'(e_stall));
        chk("m_ifid_stall",  CPU_WIDTH'(ifid_stall),  CPU_WIDTH'(e_stall));
        chk("m_ifid_flush",  CPU_WIDTH'(ifid_flush),  CPU_WIDTH'(e_flush));
        chk("m_idex_bubble", CPU_WIDTH'(idex_bubble), CPU_WIDTH'(e_bub));
        chk("m_exls_stall",  CPU_WIDTH'(exls_stall),  CPU_WIDTH'(mb));
        chk("m_ifu_drop",    CPU_WIDTH'(ifu_drop),    CPU_WIDTH'(e_drop));
        chk("m_stall_cnt",   stall_cnt,               m_stall);
        chk("m_flush_cnt",   flush_cnt,               m_flush);
        if (rst_n) begin
            if (e_stall) m_stall = m_stall + CPU_WIDTH'(1);
            if (e_flush) m_flush = m_flush + CPU_WIDTH'(1);
            if (!mb && redirect && ifu_busy) m_disc = 1'b1;
            else if (m_disc && ifu_valid)    m_disc = 1'b0;
        end
    end

    task automatic idle();
        rs1 = '0; rs2 = '0; rd = '0;
        ren1 = 1'b0; ren2 = 1'b0; ld_en = 1'b0; redirect = 1'b0;
        lsu_req = 1'b0; lsu_ready = 1'b0; ifu_busy = 1'b0; ifu_valid = 1'b0;
    endtask

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic settle();
        @(negedge clk);
        #1;
    endtask

    initial begin
        rst_n = 1'b0;
        idle();
        #12;
        chk("rst_pc_stall", CPU_WIDTH'(pc_stall), '0);
        chk("rst_ifu_drop", CPU_WIDTH'(ifu_drop), '0);
        chk("rst_stall_cnt", stall_cnt, '0);
        next_cycle();
        rst_n = 1'b1;

        // Load-use on x5
        next_cycle();
        ld_en = 1'b1; rd = REG_ADDRW'(5); rs1 = REG_ADDRW'(5); ren1 = 1'b1;
        settle();
        chk("lu_pc_stall", CPU_WIDTH'(pc_stall), CPU_WIDTH'(1));
        chk("lu_ifid_stall", CPU_WIDTH'(ifid_stall), CPU_WIDTH'(1));
        chk("lu_bubble", CPU_WIDTH'(idex_bubble), CPU_WIDTH'(1));
        chk("lu_cnt_before", stall_cnt, CPU_WIDTH'(0));
        next_cycle();
        idle();
        settle();
        chk("lu_one_cycle", CPU_WIDTH'(pc_stall), CPU_WIDTH'(0));
        chk("lu_cnt_after", stall_cnt, CPU_WIDTH'(1));

        // Load to x0 is never a hazard
        next_cycle();
        ld_en = 1'b1; ren1 = 1'b1;
        settle();
        chk("x0_no_stall", CPU_WIDTH'(pc_stall), CPU_WIDTH'(0));

        // Three frozen cycles, then completion
        for (int i = 0; i < 3; i++) begin
            next_cycle();
            idle();
            lsu_req = 1'b1;
            settle();
            chk("mem_pc_stall", CPU_WIDTH'(pc_stall), CPU_WIDTH'(1));
            chk("mem_exls", CPU_WIDTH'(exls_stall), CPU_WIDTH'(1));
            chk("mem_no_bubble", CPU_WIDTH'(idex_bubble), CPU_WIDTH'(0));
        end
        next_cycle();
        lsu_ready = 1'b1;
        settle();
        chk("mem_done_unfrozen", CPU_WIDTH'(pc_stall), CPU_WIDTH'(0));
        next_cycle();
        idle();
        settle();
        chk("mem_stall_cnt", stall_cnt, CPU_WIDTH'(4));

        // Redirect with an outstanding fetch, data returns two cycles later
        next_cycle();
        redirect = 1'b1; ifu_busy = 1'b1;
        settle();
        chk("rd_flush", CPU_WIDTH'(ifid_flush), CPU_WIDTH'(1));
        chk("rd_bubble", CPU_WIDTH'(idex_bubble), CPU_WIDTH'(1));
        chk("rd_no_pc_stall", CPU_WIDTH'(pc_stall), CPU_WIDTH'(0));
        next_cycle();
        redirect = 1'b0;
        settle();
        chk("rd_wait_drop", CPU_WIDTH'(ifu_drop), CPU_WIDTH'(0));
        chk("rd_flush_cnt", flush_cnt, CPU_WIDTH'(1));
        next_cycle();
        ifu_busy = 1'b0; ifu_valid = 1'b1;
        settle();
        chk("rd_drop", CPU_WIDTH'(ifu_drop), CPU_WIDTH'(1));
        next_cycle();
        settle();
        chk("rd_back_to_run", CPU_WIDTH'(ifu_drop), CPU_WIDTH'(0));

        // Redirect beats load-use; memory freeze beats redirect
        next_cycle();
        idle();
        redirect = 1'b1; ld_en = 1'b1; rd = REG_ADDRW'(7); rs2 = REG_ADDRW'(7); ren2 = 1'b1;
        settle();
        chk("rdlu_flush", CPU_WIDTH'(ifid_flush), CPU_WIDTH'(1));
        chk("rdlu_pc_stall", CPU_WIDTH'(pc_stall), CPU_WIDTH'(0));
        next_cycle();
        idle();
        redirect = 1'b1; lsu_req = 1'b1;
        settle();
        chk("rdmb_flush", CPU_WIDTH'(ifid_flush), CPU_WIDTH'(0));
        chk("rdmb_pc_stall", CPU_WIDTH'(pc_stall), CPU_WIDTH'(1));
        next_cycle();
        idle();
        settle();
        chk("rdmb_flush_cnt", flush_cnt, CPU_WIDTH'(2));

        // Asynchronous reset in the middle of a discard
        next_cycle();
        redirect = 1'b1; ifu_busy = 1'b1;
        next_cycle();
        idle();
        ifu_valid = 1'b1;
        #1;
        chk("pre_rst_drop", CPU_WIDTH'(ifu_drop), CPU_WIDTH'(1));
        rst_n = 1'b0;
        #1;
        chk("arst_drop", CPU_WIDTH'(ifu_drop), CPU_WIDTH'(0));
        chk("arst_stall_cnt", stall_cnt, CPU_WIDTH'(0));
        chk("arst_flush_cnt", flush_cnt, CPU_WIDTH'(0));
        next_cycle();
        idle();
        rst_n = 1'b1;
        settle();
        chk("post_rst_drop", CPU_WIDTH'(ifu_drop), CPU_WIDTH'(0));

        // Random traffic, checked by the model every cycle
        for (int c = 0; c < 4000; c++) begin
            next_cycle();
            rst_n     = ($urandom_range(0, 599) != 0);
            rs1       = REG_ADDRW'($urandom_range(0, 3));
            rs2       = REG_ADDRW'($urandom_range(0, 3));
            rd        = REG_ADDRW'($urandom_range(0, 3));
            ren1      = 1'($urandom_range(0, 1));
            ren2      = 1'($urandom_range(0, 1));
            ld_en     = ($urandom_range(0, 2) == 0);
            redirect  = ($urandom_range(0, 4) == 0);
            lsu_req   = ($urandom_range(0, 2) == 0);
            lsu_ready = 1'($urandom_range(0, 1));
            ifu_busy  = 1'($urandom_range(0, 1));
            ifu_valid = ($urandom_range(0, 3) == 0);
        end
        next_cycle();
        rst_n = 1'b1;
        idle();
        settle();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
